// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - SISC instruction fetch: program counter, branch targets, imem req/ack fetch FSM
module fetch_unit #(
    parameter int              PC_W    = 16,
    parameter int              INSTR_W = 32,
    parameter logic [PC_W-1:0] RST_VEC = '0,
    parameter int              TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_f,
    input  logic               pc_rst,
    input  logic               pc_write,
    input  logic               pc_sel,
    input  logic               br_sel,
    input  logic               ir_load,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ack,
    output logic               fetch_busy,
    output logic               fetch_err,
    output logic [PC_W-1:0]    pc_out,
    output logic [INSTR_W-1:0] ir_out,
    output logic [3:0]         opcode,
    output logic [3:0]         mm,
    output logic [15:0]        imm
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t             state_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_d;
    logic [PC_W-1:0]    addr_q;
    logic [INSTR_W-1:0] ir_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               req_q;
    logic               busy_q;
    logic               err_q;
    logic [PC_W-1:0]    imm_pc;

    // Immediate is zero-extended or truncated to the PC width.
    assign imm_pc = PC_W'(ir_q[15:0]);

    always_comb begin
        pc_d = pc_q;
        if (pc_rst) begin
            pc_d = RST_VEC;
        end else if (pc_write) begin
            if (!pc_sel)
                pc_d = pc_q + PC_W'(1);
            else if (br_sel)
                pc_d = imm_pc;
            else
                pc_d = pc_q + imm_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= IDLE;
            pc_q    <= RST_VEC;
            addr_q  <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc_q <= pc_d;
            case (state_q)
                IDLE: begin
                    if (ir_load) begin
                        // Address is the PC before any same-edge update.
                        addr_q  <= pc_q;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        ir_q    <= imem_rdata;
                        req_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        req_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ERR;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ERR: begin
                    if (pc_rst) begin
                        err_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign fetch_busy = busy_q;
    assign fetch_err  = err_q;
    assign pc_out     = pc_q;
    assign ir_out     = ir_q;
    assign opcode     = ir_q[31:28];
    assign mm         = ir_q[27:24];
    assign imm        = ir_q[15:0];

endmodule
